// File: rtl/dff_bank_arbiter_pkg.sv
// Purpose: shared encodings and default sizes for the two-requester bank arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dff_bank_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/dff_bank_arbiter_bank.sv
// Purpose: DEPTH x WIDTH flop bank, per-word write enable, synchronous active-low clear.
// Latency: write lands on the enabled edge; read is a combinational mux of current state.
// Backpressure: none; every enabled word is written on the edge it is enabled.
module dff_bank
    import dff_bank_arbiter_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [DEPTH-1:0] we,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next word value: enabled words take the write data, the rest hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = we[i] ? wdata : mem_q[i];
        end
    end

    // Word storage; clear wins over any pending write.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Old value is visible until the write edge since the read taps the flops.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/dff_bank_arbiter.sv
// Purpose: arbitrates two write requesters into a flop bank (round-robin, or fixed A-priority with ARB_FIXED_PRIO_EN).
// Latency: req at edge E -> gnt during E+1 -> bank written at E+2; rd_data combinational.
// Backpressure: at most one write per two cycles; requests seen during GRANT are ignored.
module dff_bank_arbiter
    import dff_bank_arbiter_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [AW-1:0]    addr_a,
    input  logic [AW-1:0]    addr_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             busy
);

    arb_state_e       state_q, state_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic [AW-1:0]    hold_addr_q, hold_addr_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic [DEPTH-1:0] bank_we;
    req_id_e          winner;

`ifdef ARB_FIXED_PRIO_EN
    // A always takes contention; B only wins when it is the sole requester.
    always_comb begin
        winner = req_a ? REQ_A : REQ_B;
    end
`else
    req_id_e last_win_q, last_win_d;

    // Contention goes to whoever did not win last; a sole requester always wins.
    always_comb begin
        if (req_a && req_b) begin
            winner = (last_win_q == REQ_A) ? REQ_B : REQ_A;
        end else if (req_a) begin
            winner = REQ_A;
        end else begin
            winner = REQ_B;
        end
    end

    // Remember the winner only when a grant is actually issued.
    always_comb begin
        last_win_d = last_win_q;
        if (state_q == IDLE && (req_a || req_b)) begin
            last_win_d = winner;
        end
    end

    // Round-robin history; B after reset so A wins the first contention.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_win_q <= REQ_B;
        end else begin
            last_win_q <= last_win_d;
        end
    end
`endif

    // FSM next state: capture the winner in IDLE, commit the held write in GRANT.
    always_comb begin
        state_d     = state_q;
        gnt_a_d     = 1'b0;
        gnt_b_d     = 1'b0;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        bank_we     = '0;
        case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    state_d     = GRANT;
                    gnt_a_d     = (winner == REQ_A);
                    gnt_b_d     = (winner == REQ_B);
                    hold_addr_d = (winner == REQ_A) ? addr_a : addr_b;
                    hold_data_d = (winner == REQ_A) ? data_a : data_b;
                end
            end
            GRANT: begin
                state_d              = IDLE;
                bank_we[hold_addr_q] = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, grant and holding registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_a_q     <= gnt_a_d;
            gnt_b_q     <= gnt_b_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    dff_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .clr_n   (reset),
        .we      (bank_we),
        .wdata   (hold_data_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Purpose: self-checking bench for dff_bank_arbiter with a transaction-level model.
// Latency: checks outputs 1ns after every rising edge, inputs driven on falling edges.
// Backpressure: n/a.
module tb_dff_bank_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [1:0] addr_a, addr_b, rd_addr;
    logic [7:0] data_a, data_b, rd_data;
    logic       gnt_a, gnt_b, busy;

    int tests = 0;
    int fails = 0;

    // Model: bank contents plus at most one granted write in flight.
    bit [7:0] mbank [4];
    bit       pend;
    bit       pend_b;
    bit [1:0] pend_addr;
    bit [7:0] pend_data;
    bit       mlast_b;

    always #5 clk = ~clk;

    dff_bank_arbiter #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req_a   (req_a),
        .req_b   (req_b),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .data_a  (data_a),
        .data_b  (data_b),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .busy    (busy)
    );

    task automatic model_edge();
        bit who_b;
        if (!reset) begin
            for (int i = 0; i < 4; i++) mbank[i] = 8'h00;
            pend    = 1'b0;
            mlast_b = 1'b1;
        end else if (pend) begin
            mbank[pend_addr] = pend_data;
            pend = 1'b0;
        end else if (req_a || req_b) begin
            if (req_a && req_b) begin
`ifdef ARB_FIXED_PRIO_EN
                who_b = 1'b0;
`else
                who_b = !mlast_b;
`endif
            end else begin
                who_b = req_b;
            end
            pend      = 1'b1;
            pend_b    = who_b;
            pend_addr = who_b ? addr_b : addr_a;
            pend_data = who_b ? data_b : data_a;
            mlast_b   = who_b;
        end
    endtask

    task automatic check_cycle();
        logic [10:0] act, exp;
        act = {gnt_a, gnt_b, busy, rd_data};
        exp = {pend && !pend_b, pend && pend_b, pend, mbank[rd_addr]};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL cycle t=%0t actual gnt_a/gnt_b/busy/rd_data=%b/%b/%b/%h required %b/%b/%b/%h",
                     $time, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // One clock: sample on the rising edge, compare, return on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_cycle();
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        int     code;
        int     exp_code [8];
        reset   = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        addr_a  = '0;
        addr_b  = '0;
        data_a  = '0;
        data_b  = '0;
        rd_addr = '0;

        // Reset state: all words zero, no grant, not busy.
        do_reset();
        step();
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            lit("reset_word", rd_data, 8'h00);
        end
        lit("reset_outs", {5'b0, gnt_a, gnt_b, busy}, 8'h00);

        // Single write by A: grant next cycle, data visible one cycle later.
        req_a = 1'b1; addr_a = 2'd2; data_a = 8'hA5;
        step();
        lit("a_gnt", {6'b0, gnt_a, gnt_b}, 8'h02);
        lit("a_busy", {7'b0, busy}, 8'h01);
        req_a = 1'b0;
        step();
        rd_addr = 2'd2;
        #1;
        lit("a_word2", rd_data, 8'hA5);
        lit("model_word2", mbank[2], 8'hA5);
        rd_addr = 2'd0;
        #1;
        lit("a_word0", rd_data, 8'h00);

        // Continuous contention on word 1.
        do_reset();
        req_a = 1'b1; req_b = 1'b1; addr_a = 2'd1; addr_b = 2'd1;
        data_a = 8'h11; data_b = 8'h22; rd_addr = 2'd1;
`ifdef ARB_FIXED_PRIO_EN
        exp_code = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
        exp_code = '{1, 0, 2, 0, 1, 0, 2, 0};
`endif
        for (int i = 0; i < 8; i++) begin
            step();
            code = gnt_a ? 1 : (gnt_b ? 2 : 0);
            lit("contend_gnt", 8'(code), 8'(exp_code[i]));
            lit("contend_busy", {7'b0, busy}, (i % 2 == 0) ? 8'h01 : 8'h00);
        end
        req_a = 1'b0; req_b = 1'b0;
        #1;
`ifdef ARB_FIXED_PRIO_EN
        lit("contend_word1", rd_data, 8'h11);
`else
        lit("contend_word1", rd_data, 8'h22);
`endif

        // A holding req through its grant is re-granted two cycles later.
        do_reset();
        req_a = 1'b1; addr_a = 2'd0; data_a = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step();
            lit("rehold_gnt_a", {7'b0, gnt_a}, (i == 1) ? 8'h00 : 8'h01);
            lit("rehold_busy", {7'b0, busy}, (i == 1) ? 8'h00 : 8'h01);
        end
        req_a = 1'b0;
        step();

        // Inputs changing during GRANT leave the held write intact.
        req_b = 1'b1; addr_b = 2'd3; data_b = 8'h3C;
        step();
        lit("hold_gnt_b", {6'b0, gnt_a, gnt_b}, 8'h01);
        data_b = 8'hFF; addr_b = 2'd0; req_b = 1'b0;
        req_a = 1'b1; addr_a = 2'd3; data_a = 8'hEE;
        step();
        req_a = 1'b0;
        rd_addr = 2'd3;
        #1;
        lit("hold_word3", rd_data, 8'h3C);
        step();
        lit("hold_word3_after", rd_data, 8'h3C);

        // Reset during GRANT aborts the write.
        req_a = 1'b1; addr_a = 2'd0; data_a = 8'h77;
        step();
        lit("abort_gnt_a", {7'b0, gnt_a}, 8'h01);
        reset = 1'b0; req_a = 1'b0;
        step();
        rd_addr = 2'd0;
        #1;
        lit("abort_gnt", {6'b0, gnt_a, gnt_b}, 8'h00);
        lit("abort_word0", rd_data, 8'h00);
        reset = 1'b1;
        step();
        lit("abort_idle", {7'b0, busy}, 8'h00);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset   = ($urandom_range(63) != 0);
            req_a   = $urandom_range(1) == 1;
            req_b   = $urandom_range(1) == 1;
            addr_a  = 2'($urandom_range(3));
            addr_b  = 2'($urandom_range(3));
            data_a  = 8'($urandom_range(255));
            data_b  = 8'($urandom_range(255));
            rd_addr = 2'($urandom_range(3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
